// File: rtl/mc_fetch_unit_if.sv
// rtl/mc_fetch_unit_if.sv - fetch unit handshake/memory bundle
//
// Purpose: groups the controller request, memory read and instruction
// handshake signals of mc_fetch_unit. The fetch unit uses the slave modport;
// the controller/memory side uses the master modport.
// Signals:
//   start, fetch_addr, flush   controller request / abort
//   mem_read, mem_addr         read request toward memory
//   mem_data, mem_ready        read data and beat-accept from memory
//   instr, instr_valid         assembled instruction toward consumers
//   instr_ack                  consumer takes instr
//   busy, fault                status (fault: one-cycle timeout pulse)
interface mc_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 32
);
    logic               start;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               flush;
    logic               mem_read;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic               mem_ready;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ack;
    logic               busy;
    logic               fault;

    modport master (
        output start, fetch_addr, flush, mem_data, mem_ready, instr_ack,
        input  mem_read, mem_addr, instr, instr_valid, busy, fault
    );

    modport slave (
        input  start, fetch_addr, flush, mem_data, mem_ready, instr_ack,
        output mem_read, mem_addr, instr, instr_valid, busy, fault
    );
endinterface

// File: rtl/mc_fetch_unit.sv
// rtl/mc_fetch_unit.sv - multicycle instruction fetch unit
//
// Purpose: assembles one INSTR_W-bit instruction from INSTR_W/DATA_W reads of
// a DATA_W-wide memory, with mem_ready wait states and a valid/ack handshake
// toward the controller. States IDLE -> REQ -> HOLD; back-to-back fetch goes
// HOLD -> REQ directly when instr_ack and start coincide.
// Ports:
//   ph1    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    mc_fetch_unit_if.slave (request, memory and instruction signals)
// Optional feature: define MC_FETCH_TIMEOUT_EN to abort a fetch to IDLE with a
// one-cycle fault pulse after TIMEOUT consecutive wait cycles.
module mc_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int BIG_ENDIAN = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic           ph1,
    input  logic           reset,
    mc_fetch_unit_if.slave bus
);
    localparam int BEATS = INSTR_W / DATA_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t             r_state;
    logic [BW-1:0]      r_beat;
    logic [ADDR_W-1:0]  r_base;
    logic [INSTR_W-1:0] r_instr;
    logic               r_mem_read;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_instr_valid;
    logic               r_busy;
    logic               r_fault;

`ifdef MC_FETCH_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT + 1);
    logic [WC_W-1:0]    r_wait;
`endif

    logic               w_last;
    logic [BW-1:0]      w_slot;
    logic [ADDR_W-1:0]  w_next_addr;

    assign w_last      = (r_beat == BW'(BEATS - 1));
    // Big-endian places beat 0 in the top slice of the instruction.
    assign w_slot      = (BIG_ENDIAN != 0) ? (BW'(BEATS - 1) - r_beat) : r_beat;
    // Address of the following beat; wraps naturally at 2^ADDR_W.
    assign w_next_addr = r_base + ADDR_W'(r_beat) + ADDR_W'(1);

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state       <= IDLE;
            r_beat        <= '0;
            r_base        <= '0;
            r_instr       <= '0;
            r_mem_read    <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
`ifdef MC_FETCH_TIMEOUT_EN
            r_wait        <= '0;
`endif
        end else begin
            r_fault <= 1'b0;
            if (bus.flush) begin
                // Partial instr contents are kept but never flagged valid.
                r_state       <= IDLE;
                r_beat        <= '0;
                r_mem_read    <= 1'b0;
                r_instr_valid <= 1'b0;
                r_busy        <= 1'b0;
`ifdef MC_FETCH_TIMEOUT_EN
                r_wait        <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_state    <= REQ;
                            r_base     <= bus.fetch_addr;
                            r_beat     <= '0;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.fetch_addr;
                            r_busy     <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (bus.mem_ready) begin
                            r_instr[w_slot*DATA_W +: DATA_W] <= bus.mem_data;
`ifdef MC_FETCH_TIMEOUT_EN
                            r_wait <= '0;
`endif
                            if (w_last) begin
                                r_state       <= HOLD;
                                r_mem_read    <= 1'b0;
                                r_instr_valid <= 1'b1;
                            end else begin
                                r_beat     <= r_beat + BW'(1);
                                r_mem_addr <= w_next_addr;
                            end
                        end
`ifdef MC_FETCH_TIMEOUT_EN
                        // Abort on the edge where the wait count would reach TIMEOUT.
                        else if (r_wait == WC_W'(TIMEOUT - 1)) begin
                            r_state    <= IDLE;
                            r_beat     <= '0;
                            r_mem_read <= 1'b0;
                            r_busy     <= 1'b0;
                            r_fault    <= 1'b1;
                            r_wait     <= '0;
                        end else begin
                            r_wait <= r_wait + WC_W'(1);
                        end
`endif
                    end
                    HOLD: begin
                        if (bus.instr_ack) begin
                            r_instr_valid <= 1'b0;
                            if (bus.start) begin
                                r_state    <= REQ;
                                r_base     <= bus.fetch_addr;
                                r_beat     <= '0;
                                r_mem_read <= 1'b1;
                                r_mem_addr <= bus.fetch_addr;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state       <= IDLE;
                        r_beat        <= '0;
                        r_mem_read    <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_read    = r_mem_read;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.busy        = r_busy;
    assign bus.fault       = r_fault;
endmodule

// File: doc/mc_fetch_unit.md
# mc_fetch_unit

Parametrised multicycle instruction fetch unit for the multicycle MIPS core. It assembles one INSTR_W-bit instruction from a DATA_W-wide memory over INSTR_W/DATA_W read beats, replacing the fixed four-strobe byte IRWrite scheme. It adds a memory wait-state handshake (mem_ready) and a valid/ack handshake toward the controller. It sits between the PC/IorD address path and the instruction register consumers.

## Interface
- ADDR_W, 8, memory address width; addresses in DATA_W-wide words
- DATA_W, 8, memory data width; INSTR_W % DATA_W == 0 required
- INSTR_W, 32, instruction width
- BIG_ENDIAN, 0, 0: beat 0 fills instr[DATA_W-1:0]; 1: beat 0 fills the top slice
- TIMEOUT, 15, wait-state limit (used only with MC_FETCH_TIMEOUT_EN)
- BEATS (local) = INSTR_W/DATA_W

Ports:
- ph1  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request fetch at fetch_addr
- fetch_addr  in  ADDR_W  base word address
- flush  in  1  synchronous abort
- mem_read  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_data  in  DATA_W  read data, valid when mem_ready
- mem_ready  in  1  beat accepted this cycle
- instr  out  INSTR_W  assembled instruction
- instr_valid  out  1  instr complete and stable
- instr_ack  in  1  consumer takes instr
- busy  out  1  state != IDLE
- fault  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, REQ, HOLD. Reset forces IDLE, beat=0, base=0, instr=0, all outputs 0.
- IDLE: start=1 latches base=fetch_addr, beat=0, then go to REQ.
- REQ: mem_read=1, mem_addr=(base+beat) mod 2^ADDR_W.
  - mem_ready=1 at an edge writes mem_data into slice beat (or BEATS-1-beat if BIG_ENDIAN).
  - After that write: if beat==BEATS-1, go to HOLD; else beat+1.
  - mem_ready=0 holds all state.
- HOLD: instr_valid=1, instr stable.
  - instr_ack=1 with start=1 latches the new base and goes to REQ (back-to-back, no idle cycle).
  - instr_ack=1 with start=0 goes to IDLE.
- start is ignored in REQ and in HOLD without instr_ack.
- flush=1 from any state goes to IDLE, beat=0, with instr_valid and mem_read low the next cycle. The instr register keeps its partial contents but is never flagged valid.
- flush has priority over start, instr_ack and mem_ready in the same cycle. reset has priority over everything.
- Address wrap: base+beat wraps modulo 2^ADDR_W with no fault.
- mem_addr holds its last value when not reading (reset value 0).
- busy is registered state decode.

## Timing
- start sampled at edge 0. mem_read is high in cycles 1..BEATS with no waits. instr_valid rises in cycle BEATS+1.
- Latency = BEATS+1 cycles, plus one per wait cycle (mem_ready low while mem_read high).
- mem_addr and mem_read are valid from the edge that enters or advances REQ. Memory must return data combinationally with mem_ready in the same cycle.
- instr_valid stays high until the edge sampling instr_ack=1 (or flush).
- Back-to-back fetch: the instr_valid cycle is followed directly by mem_read of the next fetch. Sustained throughput is one instruction per BEATS+1 cycles.

## Configuration
- MC_FETCH_TIMEOUT_EN defined:
  - A wait counter (width clog2(TIMEOUT+1)) counts consecutive REQ cycles with mem_ready=0 and clears on mem_ready=1 or on leaving REQ.
  - On the edge where the count reaches TIMEOUT, go to IDLE, beat=0, and pulse fault for one cycle. instr_valid is not asserted.
  - flush in the same cycle suppresses the fault.
- MC_FETCH_TIMEOUT_EN undefined: REQ waits indefinitely, fault is tied 0, and no counter is present.

## Test plan
- Defaults, no waits: start with fetch_addr=0x10; memory returns 0x78,0x56,0x34,0x12 at 0x10..0x13. Expect mem_read cycles 1–4, instr_valid in cycle 5, instr=0x12345678. With BIG_ENDIAN=1, expect instr=0x78563412.
- Wait states: mem_ready low for 2 cycles on beat 1. Expect instr_valid in cycle 7, same instr, and mem_addr held at 0x11 during the waits.
- Wrap and back-to-back: fetch_addr=0xFE gives addresses 0xFE,0xFF,0x00,0x01. In the HOLD cycle assert instr_ack and start together with fetch_addr=0x20. Expect mem_read=1 at 0x20 the very next cycle.
- Flush and reset mid-fetch: flush during beat 2 returns to IDLE with instr_valid never asserted; a subsequent start at 0x10 yields a correct instr. reset during REQ gives all outputs 0 the next cycle.
- DATA_W=16, INSTR_W=32: data 0x5678, 0x1234 at 0x08, 0x09. Expect instr=0x12345678 in cycle 3.
- MC_FETCH_TIMEOUT_EN with TIMEOUT=15: mem_ready held low. Expect fault high for exactly one cycle 15 cycles after REQ entry, then busy=0. Without the macro, busy stays 1 and fault stays 0 for 100 cycles.
